// File: rtl/mem_bus_if.sv
// ---------------------------------------------------------------------------
// mem_bus_if
//
// Strobe-based word bus between the 16-bit CPU (MAR/MDR + control FSM) and
// the memory responder.
//
//   ADDR          CPU -> mem   word address from MAR
//   Data_from_CPU CPU -> mem   write data from MDR
//   Mem_OE        CPU -> mem   read strobe, held for the access latency
//   Mem_WE        CPU -> mem   write strobe, held for the access latency
//   Data_to_CPU   mem -> CPU   registered read data
//   Mem_Ack       mem -> CPU   one-cycle completion pulse
//   Busy          mem -> CPU   access currently counting
//   Err           mem -> CPU   both strobes were seen high together
// ---------------------------------------------------------------------------
interface mem_bus_if;
    logic [15:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] Data_to_CPU;
    logic        Mem_Ack;
    logic        Busy;
    logic        Err;

    modport master (
        output ADDR, Data_from_CPU, Mem_OE, Mem_WE,
        input  Data_to_CPU, Mem_Ack, Busy, Err
    );

    modport slave (
        input  ADDR, Data_from_CPU, Mem_OE, Mem_WE,
        output Data_to_CPU, Mem_Ack, Busy, Err
    );
endinterface

// File: rtl/mem_bus_responder.sv
// ---------------------------------------------------------------------------
// mem_bus_responder
//
// Memory-side responder for the CPU's SRAM strobe bus. Answers multi-cycle
// Mem_OE / Mem_WE strobes with a fixed-latency on-chip word RAM and exposes a
// single memory-mapped I/O word: reads there return the board switches,
// writes there update the hex-display register.
//
// Parameters
//   ADDR_W   RAM index width (2^ADDR_W 16-bit words)
//   LAT      strobe cycles per access, 2..8
//   IO_ADDR  memory-mapped I/O word address
//
// Ports
//   Clk       clock, rising edge
//   Reset     synchronous, active-high
//   bus       slave side of mem_bus_if (address/data/strobes/ack/busy/err)
//   Switches  board switches, read at IO_ADDR
//   HEX_Data  registered hex-display word, written at IO_ADDR
// ---------------------------------------------------------------------------
module mem_bus_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LAT     = 3,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    mem_bus_if.slave    bus,
    input  logic [15:0] Switches,
    output logic [15:0] HEX_Data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(LAT + 1);

    // A read must present data during strobe cycle LAT, so it completes one
    // edge earlier than a write, which samples its data at the LAT-th edge.
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic logic is_io(input logic [15:0] a);
        return a == IO_ADDR;
    endfunction

    // Non-I/O addresses alias on the low ADDR_W bits.
    function automatic logic [ADDR_W-1:0] ram_index(input logic [15:0] a);
        return a[ADDR_W-1:0];
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic             hold_wr_q, hold_wr_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [15:0]      hex_q, hex_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [15:0]      ram [DEPTH];
    logic             ram_we;

    logic             oe;
    logic             we;
    logic             both;
    logic [CNT_W-1:0] cnt_inc;
    logic [15:0]      rd_addr;
    logic [15:0]      rd_word;

    assign oe      = bus.Mem_OE;
    assign we      = bus.Mem_WE;
    assign both    = oe & we;
    assign cnt_inc = cnt_q + CNT_ONE;

    // With LAT=2 the read completes on the very first strobe edge, before
    // the address has been latched, so the live bus address is used there.
    assign rd_addr = (state_q == IDLE) ? bus.ADDR : addr_q;
    assign rd_word = is_io(rd_addr) ? Switches : ram[ram_index(rd_addr)];

    // ---- next-state / output logic ----
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        hold_wr_d = hold_wr_q;
        rdata_d   = rdata_q;
        hex_d     = hex_q;
        ack_d     = 1'b0;
        err_d     = both;
        ram_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (both) begin
                    state_d = IDLE;
                end else if (oe) begin
                    addr_d    = bus.ADDR;
                    hold_wr_d = 1'b0;
                    if (LAT == 2) begin
                        rdata_d = rd_word;
                        ack_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = RD;
                    end
                end else if (we) begin
                    addr_d    = bus.ADDR;
                    hold_wr_d = 1'b1;
                    cnt_d     = CNT_ONE;
                    state_d   = WR;
                end
            end

            RD: begin
                if (both || !oe) begin
                    // Error or early strobe drop: abandon without side effects.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_inc == RD_LAST) begin
                    rdata_d = rd_word;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            WR: begin
                if (both || !we) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_inc == WR_LAST) begin
                    if (is_io(addr_q)) begin
                        hex_d = bus.Data_from_CPU;
                    end else begin
                        ram_we = ~Reset;
                    end
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            HOLD: begin
                // Swallow the remainder of a long strobe so one assertion
                // can never produce a second access or acknowledge.
                if (both || !(hold_wr_q ? we : oe)) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RD) || (state_d == WR);
    end

    // ---- control and output registers ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_wr_q <= 1'b0;
            rdata_q   <= '0;
            hex_q     <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_wr_q <= hold_wr_d;
            rdata_q   <= rdata_d;
            hex_q     <= hex_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // ---- data-only storage (no reset) ----
    always_ff @(posedge Clk) begin
        addr_q <= addr_d;
        if (ram_we) begin
            ram[ram_index(addr_q)] <= bus.Data_from_CPU;
        end
    end

    assign bus.Data_to_CPU = rdata_q;
    assign bus.Mem_Ack     = ack_q;
    assign bus.Busy        = busy_q;
    assign bus.Err         = err_q;
    assign HEX_Data        = hex_q;

endmodule
